// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// The BLANK state exists only when SEVEN_SEG_ARB_BLANK_EN is defined.
package seven_seg_pkg;

  localparam int unsigned DataWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StShow
`ifdef SEVEN_SEG_ARB_BLANK_EN
    ,
    StBlank
`endif
  } state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Loadable up-counter: counts from 0 to a stored terminal value and holds there.
// done_o is high while the count sits on the terminal value.
module ms_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] last_i,
  output logic             done_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      last_q  <= '0;
    end else if (load_i) begin
      count_q <= '0;
      last_q  <= last_i;
    end else if (count_q != last_q) begin
      // Saturate on the terminal value so the counter never wraps.
      count_q <= count_q + Width'(1);
    end
  end

  assign done_o = (count_q == last_q);

endmodule

// File: rtl/seven_seg_arbiter.sv
// Two-requester arbiter that grants the seven-segment display for a minimum hold time.
// Define SEVEN_SEG_ARB_BLANK_EN to insert a dark gap (BLANK_MS) between owners.
module seven_seg_arbiter
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned HOLD_MS  = 500
`ifdef SEVEN_SEG_ARB_BLANK_EN
  ,
  parameter int unsigned BLANK_MS = 50
`endif
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req0_valid_i,
  input  logic [DataWidth-1:0] req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [DataWidth-1:0] req1_data_i,
  output logic                 req1_ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 owner_o,
  output logic                 busy_o,
  output logic                 blank_o
);

  localparam int unsigned HOLD_CYCLES = ms_to_cycles(CLK_FREQ, HOLD_MS);
`ifdef SEVEN_SEG_ARB_BLANK_EN
  localparam int unsigned BLANK_CYCLES = ms_to_cycles(CLK_FREQ, BLANK_MS);
  localparam int unsigned MaxCycles = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
`else
  localparam int unsigned MaxCycles = HOLD_CYCLES;
`endif
  localparam int unsigned CntWidth = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_CYCLES - 1);
`ifdef SEVEN_SEG_ARB_BLANK_EN
  localparam logic [CntWidth-1:0] BlankLast = CntWidth'(BLANK_CYCLES - 1);
`endif

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;

  logic                 ready0, ready1;
  logic                 hs0, hs1;
  logic                 tmr_load;
  logic [CntWidth-1:0]  tmr_last;
  logic                 tmr_done;

  ms_timer #(
    .Width (CntWidth)
  ) u_ms_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (tmr_load),
    .last_i  (tmr_last),
    .done_o  (tmr_done)
  );

  // Ready is combinational and forced low during reset so no handshake can complete.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!reset_i) begin
      case (state_q)
        StIdle: begin
          if (req0_valid_i && req1_valid_i) begin
            ready0 = last_grant_q;
            ready1 = !last_grant_q;
          end else begin
            ready0 = req0_valid_i;
            ready1 = req1_valid_i;
          end
        end
        StShow: begin
          ready0 = !owner_q;
          ready1 = owner_q;
        end
        default: ;
      endcase
    end
  end

  assign hs0 = req0_valid_i && ready0;
  assign hs1 = req1_valid_i && ready1;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tmr_load     = 1'b0;
    tmr_last     = HoldLast;
    case (state_q)
      StIdle: begin
        if (hs0 || hs1) begin
          data_d       = hs1 ? req1_data_i : req0_data_i;
          owner_d      = hs1;
          last_grant_d = hs1;
          tmr_load     = 1'b1;
          state_d      = StShow;
        end
      end
      StShow: begin
        // Owner updates refresh the word without touching the hold count.
        if (hs0 || hs1) begin
          data_d = hs1 ? req1_data_i : req0_data_i;
        end
        if (tmr_done) begin
`ifdef SEVEN_SEG_ARB_BLANK_EN
          state_d  = StBlank;
          tmr_load = 1'b1;
          tmr_last = BlankLast;
`else
          state_d  = StIdle;
`endif
        end
      end
`ifdef SEVEN_SEG_ARB_BLANK_EN
      StBlank: begin
        if (tmr_done) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      data_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready_o = ready0;
  assign req1_ready_o = ready1;
  assign data_o       = data_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q != StIdle);
`ifdef SEVEN_SEG_ARB_BLANK_EN
  assign blank_o      = (state_q == StBlank);
`else
  assign blank_o      = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Directed bench for seven_seg_arbiter at 100 kHz with 1 ms hold (100 cycles).
// Builds with or without SEVEN_SEG_ARB_BLANK_EN; blank-gap checks apply only when defined.
module tb_seven_seg_arbiter;

  localparam int unsigned Hold = 100;
`ifdef SEVEN_SEG_ARB_BLANK_EN
  localparam int unsigned Blank = 100;
`else
  localparam int unsigned Blank = 0;
`endif
  localparam int unsigned ExpBusy = Hold + Blank;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0_valid_i, req1_valid_i;
  logic [15:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o;
  logic [15:0] data_o;
  logic        owner_o, busy_o, blank_o;

  int n_checks = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_arbiter #(
    .CLK_FREQ (100000),
    .HOLD_MS  (1)
`ifdef SEVEN_SEG_ARB_BLANK_EN
    ,
    .BLANK_MS (1)
`endif
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .data_o       (data_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o),
    .blank_o      (blank_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with busy high; an expired budget is reported as a failure.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 400) begin
      step();
      n++;
    end
    if (busy_o) check_eq("idle_timeout", busy_o, 0);
  endtask

  int n;
  int bad_rdy1, bad_busy, bad_blank;

  initial begin
    reset_i = 1'b1;
    req0_valid_i = 1'b1; req0_data_i = 16'h0000;
    req1_valid_i = 1'b1; req1_data_i = 16'h0000;

    // Reset for 5 cycles with both requesters valid.
    repeat (5) step();
    check_eq("rst_data", data_o, 16'h0000);
    check_eq("rst_owner", owner_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_blank", blank_o, 0);
    check_eq("rst_rdy0", req0_ready_o, 0);
    check_eq("rst_rdy1", req1_ready_o, 0);

    // Single requester grant and hold length.
    reset_i = 1'b0;
    req1_valid_i = 1'b0;
    req0_data_i = 16'hABCD;
    #1;
    check_eq("single_rdy0", req0_ready_o, 1);
    check_eq("single_rdy1", req1_ready_o, 0);
    step();
    req0_valid_i = 1'b0;
    check_eq("single_data", data_o, 16'hABCD);
    check_eq("single_owner", owner_o, 0);
    check_eq("single_busy", busy_o, 1);
    wait_idle(n);
    check_eq("single_busy_len", n, ExpBusy);

    // Tie-break: req0 first after reset, then alternate.
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    req0_valid_i = 1'b1; req0_data_i = 16'h1111;
    req1_valid_i = 1'b1; req1_data_i = 16'h2222;
    #1;
    check_eq("tie1_rdy0", req0_ready_o, 1);
    check_eq("tie1_rdy1", req1_ready_o, 0);
    step();
    check_eq("tie1_owner", owner_o, 0);
    check_eq("tie1_data", data_o, 16'h1111);
    check_eq("tie1_show_rdy1", req1_ready_o, 0);
    wait_idle(n);
    check_eq("tie2_rdy1", req1_ready_o, 1);
    check_eq("tie2_rdy0", req0_ready_o, 0);
    step();
    check_eq("tie2_owner", owner_o, 1);
    check_eq("tie2_data", data_o, 16'h2222);
    wait_idle(n);
    check_eq("tie3_rdy0", req0_ready_o, 1);
    step();
    check_eq("tie3_owner", owner_o, 0);
    check_eq("tie3_data", data_o, 16'h1111);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    wait_idle(n);

    // Owner updates mid-hold and in the terminal cycle; non-owner waits.
    req0_valid_i = 1'b1; req0_data_i = 16'h5555;
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_data_i = 16'h9999;
    bad_rdy1 = 0;
    bad_busy = 0;
    for (int i = 1; i <= 100; i++) begin
      if (req1_ready_o) bad_rdy1++;
      if (!busy_o) bad_busy++;
      if (i == 51) begin
        check_eq("upd_data", data_o, 16'h1234);
        req0_valid_i = 1'b0;
      end
      if (i == 50 || i == 100) begin
        req0_valid_i = 1'b1;
        req0_data_i = (i == 50) ? 16'h1234 : 16'h7777;
      end
      step();
    end
    check_eq("upd_rdy1_low", bad_rdy1, 0);
    check_eq("upd_busy_held", bad_busy, 0);
    check_eq("term_data", data_o, 16'h7777);
`ifdef SEVEN_SEG_ARB_BLANK_EN
    req0_valid_i = 1'b0;
    check_eq("blank_busy", busy_o, 1);
    bad_rdy1 = 0;
    bad_blank = 0;
    for (int i = 0; i < 100; i++) begin
      if (!blank_o) bad_blank++;
      if (req1_ready_o || req0_ready_o) bad_rdy1++;
      step();
    end
    check_eq("blank_len", bad_blank, 0);
    check_eq("blank_rdy_low", bad_rdy1, 0);
    check_eq("blank_end", blank_o, 0);
    check_eq("blank_idle_busy", busy_o, 0);
    check_eq("blank_idle_rdy1", req1_ready_o, 1);
`else
    check_eq("term_busy", busy_o, 0);
    check_eq("term_blank", blank_o, 0);
    check_eq("term_rdy1", req1_ready_o, 1);
    req0_valid_i = 1'b0;
`endif
    step();
    check_eq("pend_owner", owner_o, 1);
    check_eq("pend_data", data_o, 16'h9999);
    check_eq("pend_busy", busy_o, 1);
    req1_valid_i = 1'b0;

    // Reset at hold cycle 40 aborts; the next grant gets a full hold.
    repeat (39) step();
    reset_i = 1'b1;
    req1_valid_i = 1'b1;
    #1;
    check_eq("mid_rst_rdy1", req1_ready_o, 0);
    step();
    req1_valid_i = 1'b0;
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_data", data_o, 16'h0000);
    check_eq("mid_rst_owner", owner_o, 0);
    reset_i = 1'b0;
    req0_valid_i = 1'b1; req0_data_i = 16'h4321;
    step();
    req0_valid_i = 1'b0;
    check_eq("post_rst_data", data_o, 16'h4321);
    wait_idle(n);
    check_eq("post_rst_busy_len", n, ExpBusy);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
